calc_seq: RTL and testbench
===========================

CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pb  input  7  raw pushbuttons, active-high, asynchronous: [0] digit 0, [1] digit 1, [2] add, [3] subtract, [4] equals, [5] clear, [6] multiply (see REQ-026).
REQ-005 SHALL have port disp  output  WIDTH  value being displayed (operand under entry or result), unsigned binary.
REQ-006 SHALL have port red  output  1  overflow/borrow flag of the last computation.
REQ-007 SHALL have port blue  output  1  high while the second operand is being entered.

Function
REQ-008 SHALL pass each pb bit through a 2-flop synchroniser, then a rising-edge detector; one action per press regardless of hold length; a 1-cycle pulse is a valid press.
REQ-009 SHALL apply an action at the 3rd rising clk edge after pb is first sampled high; disp/red/blue SHALL update on that edge.
REQ-010 SHALL, on simultaneous edges, act only on the highest priority: clear > equals > multiply > subtract > add > digit 1 > digit 0; others are discarded.
REQ-011 SHALL hold registers A, B, R (WIDTH each), stored op (ADD/SUB/MUL) and state in {ENTER_A, ENTER_B, SHOW}.
REQ-012 Digit in ENTER_A: A <= {A[WIDTH-2:0], d}; MSB shifted out is discarded; red <= 0; disp = A.
REQ-013 Op in ENTER_A: store op, B <= 0, go ENTER_B; disp = B (0).
REQ-014 Equals in ENTER_A: no effect.
REQ-015 Digit in ENTER_B: B <= {B[WIDTH-2:0], d}; disp = B.
REQ-016 Op in ENTER_B: replace stored op; B unchanged; no computation.
REQ-017 Equals in ENTER_B: R <= A op B, red <= overflow, go SHOW; disp = R.
REQ-018 Digit in SHOW: A <= {0..0, d}, red <= 0, go ENTER_A.
REQ-019 Op in SHOW: A <= R (chaining), store op, B <= 0, go ENTER_B; red held.
REQ-020 Equals in SHOW: R <= R op B (repeat last op with same B), red <= overflow of this computation.
REQ-021 Clear in any state: same effect as reset (REQ-024).
REQ-022 Arithmetic unsigned modulo 2^WIDTH: ADD overflow = carry out; SUB overflow = borrow (A < B); MUL overflow = any nonzero bit above WIDTH-1 of the 2*WIDTH product.
REQ-023 blue SHALL equal (state == ENTER_B); disp SHALL be A in ENTER_A, B in ENTER_B, R in SHOW.

Reset
REQ-024 rst high at a rising edge SHALL set A=B=R=0, op=ADD, state=ENTER_A, disp=0, red=0, blue=0, and clear synchroniser/edge flops.
REQ-025 rst SHALL override any action in progress, including an edge in the synchroniser pipeline; a button held through reset release SHALL NOT generate a press.

Configuration
REQ-026 Macro CALC_MUL_EN defined: pb[6] is multiply op with REQ-022 semantics, priority per REQ-010.
REQ-027 CALC_MUL_EN undefined: no multiplier logic; pb[6] ignored entirely (no state, disp, red or blue change), port still present.

Verification (WIDTH=8)
REQ-028 rst high 2 cycles, then low -> disp=0x00, red=0, blue=0; pb[1] press -> disp=0x01 exactly 3 edges after assertion.
REQ-029 Digits 1,0,1; add (blue=1, disp=0); digits 1,1; equals -> disp=0x08, red=0, blue=0; equals again -> disp=0x0B; clear -> disp=0x00.
REQ-030 Digits 1,1; subtract; digits 1,0,1; equals -> disp=0xFE, red=1; digit 0 -> disp=0x00, red=0.
REQ-031 Nine digit-1 presses -> disp=0xFF (MSB discarded); add; digit 1; equals -> disp=0x00, red=1; pb[4]+pb[5] same cycle -> clear wins, disp=0x00, red=0.
REQ-032 Digits 1,0 (A=2); subtract; rst pulsed mid-entry of B while pb[1] high -> disp=0x00, blue=0, no press after release.
REQ-033 CALC_MUL_EN: A=0x10, multiply, B=0x10, equals -> disp=0x00, red=1; without macro same stimulus -> pb[6] ignored, blue stays 0, equals has no effect, disp=0x10.

Source files
------------

// File: rtl/calc_seq.sv
// Two-operand pushbutton calculator: synchronised buttons, entry/result FSM, unsigned ALU.
// Optional multiply op enabled by defining CALC_MUL_EN.
module calc_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       pb,
  output logic [WIDTH-1:0] disp,
  output logic             red,
  output logic             blue
);

`ifdef CALC_MUL_EN
  localparam int unsigned NumBtn = 7;
`else
  localparam int unsigned NumBtn = 6;
  logic unused_pb;
  assign unused_pb = pb[6];
`endif

  typedef enum logic [1:0] {StEnterA, StEnterB, StShow} state_e;
  typedef enum logic [1:0] {OpAdd, OpSub, OpMul} op_e;

  logic [NumBtn-1:0] sync1_q, sync2_q, prev_q, armed_q, rise;
  logic [1:0]        fill_q;

  // A bit only arms once it has been seen low through a filled pipeline, so a
  // button held across reset release never produces a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= pb[NumBtn-1:0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      else                armed_q <= armed_q | ~sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q & armed_q;

  logic do_clr, do_eq, do_op, do_dig, dig;
  op_e  new_op;

  always_comb begin
    do_clr = 1'b0;
    do_eq  = 1'b0;
    do_op  = 1'b0;
    do_dig = 1'b0;
    dig    = 1'b0;
    new_op = OpAdd;
    if (rise[5]) do_clr = 1'b1;
    else if (rise[4]) do_eq = 1'b1;
`ifdef CALC_MUL_EN
    else if (rise[6]) begin
      do_op  = 1'b1;
      new_op = OpMul;
    end
`endif
    else if (rise[3]) begin
      do_op  = 1'b1;
      new_op = OpSub;
    end else if (rise[2]) begin
      do_op  = 1'b1;
      new_op = OpAdd;
    end else if (rise[1]) begin
      do_dig = 1'b1;
      dig    = 1'b1;
    end else if (rise[0]) begin
      do_dig = 1'b1;
    end
  end

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic             red_q, red_d;

  // Left operand is A on first equals, R on repeated equals.
  logic [WIDTH-1:0] x, res;
  logic [WIDTH:0]   sum;
  logic             ovf;
`ifdef CALC_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  always_comb begin
    x   = (state_q == StShow) ? r_q : a_q;
    sum = {1'b0, x} + {1'b0, b_q};
`ifdef CALC_MUL_EN
    prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, b_q};
`endif
    res = sum[WIDTH-1:0];
    ovf = sum[WIDTH];
    case (op_q)
      OpSub: begin
        res = x - b_q;
        ovf = (x < b_q);
      end
`ifdef CALC_MUL_EN
      OpMul: begin
        res = prod[WIDTH-1:0];
        ovf = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    red_d   = red_q;
    if (do_clr) begin
      state_d = StEnterA;
      op_d    = OpAdd;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      red_d   = 1'b0;
    end else begin
      case (state_q)
        StEnterA: begin
          if (do_dig) begin
            a_d   = {a_q[WIDTH-2:0], dig};
            red_d = 1'b0;
          end else if (do_op) begin
            op_d    = new_op;
            b_d     = '0;
            state_d = StEnterB;
          end
        end
        StEnterB: begin
          if (do_dig) begin
            b_d = {b_q[WIDTH-2:0], dig};
          end else if (do_op) begin
            op_d = new_op;
          end else if (do_eq) begin
            r_d     = res;
            red_d   = ovf;
            state_d = StShow;
          end
        end
        StShow: begin
          if (do_dig) begin
            a_d     = {{(WIDTH-1){1'b0}}, dig};
            red_d   = 1'b0;
            state_d = StEnterA;
          end else if (do_op) begin
            a_d     = r_q;
            op_d    = new_op;
            b_d     = '0;
            state_d = StEnterB;
          end else if (do_eq) begin
            r_d   = res;
            red_d = ovf;
          end
        end
        default: state_d = StEnterA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEnterA;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      red_q   <= red_d;
    end
  end

  always_comb begin
    case (state_q)
      StEnterB: disp = b_q;
      StShow:   disp = r_q;
      default:  disp = a_q;
    endcase
  end

  assign red  = red_q;
  assign blue = (state_q == StEnterB);

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed scenarios plus random button traffic against an arithmetic model.
module tb_calc_seq;
  localparam int unsigned W = 8;
  localparam int Mod = 256;
`ifdef CALC_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   pb;
  logic [W-1:0] disp;
  logic         red, blue;

  calc_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .pb  (pb),
    .disp(disp),
    .red (red),
    .blue(blue)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mst 0=entering A, 1=entering B, 2=showing result; mop 0=add 1=sub 2=mul.
  int ma, mb, mr, mop, mst;
  int mred;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    ma = 0; mb = 0; mr = 0; mop = 0; mst = 0; mred = 0;
  endfunction

  function automatic int model_disp();
    if (mst == 0) return ma;
    if (mst == 1) return mb;
    return mr;
  endfunction

  function automatic void calc(input int a, input int o, input int b,
                               output int res, output int ov);
    int full;
    if (o == 1) begin
      full = a - b;
      ov   = (a < b) ? 1 : 0;
      res  = (full + Mod) % Mod;
    end else begin
      full = (o == 2) ? a * b : a + b;
      ov   = (full >= Mod) ? 1 : 0;
      res  = full % Mod;
    end
  endfunction

  function automatic void model_apply(input logic [6:0] m);
    logic [6:0] mm;
    int res, ov, o, d;
    mm = m;
    if (!MulEn) mm[6] = 1'b0;
    o = -1;
    d = -1;
    if (mm[5]) begin
      model_reset();
      return;
    end else if (mm[4]) begin
      if (mst == 1) begin
        calc(ma, mop, mb, res, ov);
        mr = res; mred = ov; mst = 2;
      end else if (mst == 2) begin
        calc(mr, mop, mb, res, ov);
        mr = res; mred = ov;
      end
      return;
    end
    else if (mm[6]) o = 2;
    else if (mm[3]) o = 1;
    else if (mm[2]) o = 0;
    else if (mm[1]) d = 1;
    else if (mm[0]) d = 0;
    if (o >= 0) begin
      if (mst == 2) ma = mr;
      if (mst != 1) mb = 0;
      mop = o;
      mst = 1;
    end else if (d >= 0) begin
      if (mst == 0) begin
        ma = (ma * 2 + d) % Mod; mred = 0;
      end else if (mst == 1) begin
        mb = (mb * 2 + d) % Mod;
      end else begin
        ma = d; mred = 0; mst = 0;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_disp"}, int'(disp), model_disp());
    check({tag, "_red"}, int'(red), mred);
    check({tag, "_blue"}, int'(blue), (mst == 1) ? 1 : 0);
  endtask

  // Drive a press for `hold` cycles; nothing may change before the third edge.
  task automatic press(input logic [6:0] m, input int hold);
    int last;
    last = (hold > 3) ? hold : 3;
    @(negedge clk) pb = m;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == hold) pb = '0;
      if (k == 2) check("early", int'(disp), model_disp());
      if (k == 3) begin
        model_apply(m);
        check_model("press");
      end
    end
    pb = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk) rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic digits(input int val, input int n);
    for (int i = n - 1; i >= 0; i--) press(((val >> i) & 1) != 0 ? 7'h02 : 7'h01, 1);
  endtask

  initial begin
    rst = 1'b0;
    pb  = '0;

    do_reset(2);
    check("rst_disp", int'(disp), 0);
    check("rst_red", int'(red), 0);
    check("rst_blue", int'(blue), 0);
    press(7'h02, 1);
    check("first_digit", int'(disp), 8'h01);

    do_reset(2);
    digits(5, 3);
    press(7'h04, 1);
    check("add_blue", int'(blue), 1);
    check("add_disp", int'(disp), 0);
    digits(3, 2);
    press(7'h10, 1);
    check("eq_sum", int'(disp), 8'h08);
    check("eq_blue", int'(blue), 0);
    press(7'h10, 1);
    check("eq_repeat", int'(disp), 8'h0B);
    press(7'h20, 1);
    check("clear", int'(disp), 0);

    digits(3, 2);
    press(7'h08, 1);
    digits(5, 3);
    press(7'h10, 2);
    check("sub_disp", int'(disp), 8'hFE);
    check("sub_borrow", int'(red), 1);
    press(7'h01, 1);
    check("dig_after", int'(disp), 0);
    check("dig_red", int'(red), 0);

    digits(9'h1FF, 9);
    check("msb_drop", int'(disp), 8'hFF);
    press(7'h04, 1);
    press(7'h02, 4);
    press(7'h10, 1);
    check("carry_disp", int'(disp), 0);
    check("carry_red", int'(red), 1);
    press(7'h30, 1);
    check("clr_prio_disp", int'(disp), 0);
    check("clr_prio_red", int'(red), 0);

    digits(8'h10, 5);
    press(7'h40, 1);
    check("mul_blue", int'(blue), MulEn ? 1 : 0);
    digits(8'h10, 5);
    press(7'h10, 1);
    check("mul_result", int'(disp), MulEn ? 0 : 8'h10);
    check("mul_red", int'(red), MulEn ? 1 : 0);

    // Reset mid-entry of B with digit 1 held across release.
    do_reset(1);
    digits(2, 2);
    press(7'h08, 1);
    press(7'h02, 1);
    @(negedge clk) pb = 7'h02;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    check("held_disp", int'(disp), 0);
    check("held_blue", int'(blue), 0);
    pb = '0;
    repeat (4) @(negedge clk);
    check_model("released");
    check("released_disp", int'(disp), 0);

    repeat (300) begin
      int r;
      logic [6:0] m;
      r = int'($urandom_range(0, 11));
      if (r <= 6) m = 7'(1 << r);
      else if (r <= 9) m = 7'(1 << $urandom_range(0, 4));
      else m = 7'($urandom_range(1, 127)) & ~7'h20;
      press(m, int'($urandom_range(1, 5)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
